// File: rtl/vga_scan_ctrl.sv
`timescale 1ns/1ps
// Raster timing and screen-buffer read-address generator (640x480@60 Hz, 25 MHz pixel clock).
// valid and the syncs are delayed so they line up with the screen RAM output and colorizer register.
module vga_scan_ctrl #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned SCALE_SHIFT = 2,
    parameter int unsigned RAM_LATENCY = 1,
    parameter int unsigned ADDR_W      = 15
) (
    input  logic              clk_25m,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              valid,
    output logic              hsync,
    output logic              vsync,
    output logic              frame_tick,
    output logic [9:0]        pix_x,
    output logic [9:0]        pix_y
);

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned BUF_W   = H_ACTIVE >> SCALE_SHIFT;
    localparam int unsigned VLD_D   = 1 + RAM_LATENCY;
    localparam int unsigned SYN_D   = 2 + RAM_LATENCY;

    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0]  h_cnt;
    logic [CNT_W-1:0]  v_cnt;
    logic [CNT_W-1:0]  h_nxt;
    logic [CNT_W-1:0]  v_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              act_c;
    logic              hs_raw_c;
    logic              vs_raw_c;
    logic              tick_c;
    logic [VLD_D-1:0]  vld_pipe;
    logic [SYN_D-1:0]  hs_pipe;
    logic [SYN_D-1:0]  vs_pipe;

    // Next raster position, stage-0 timing flags and next read address.
    always_comb begin
        h_nxt    = h_cnt + CNT_W'(1);
        v_nxt    = v_cnt;
        act_c    = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
        hs_raw_c = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
        vs_raw_c = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
        tick_c   = (h_cnt == '0) && (v_cnt == V_ACT_C);
        addr_nxt = rd_addr;
        if (h_cnt == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
        end
        // Address holds through blanking; the RAM output is ignored there anyway.
        if (act_c) begin
            addr_nxt = ADDR_W'(v_cnt >> SCALE_SHIFT) * ADDR_W'(BUF_W)
                     + ADDR_W'(h_cnt >> SCALE_SHIFT);
        end
    end

    always_ff @(posedge clk_25m) begin
        if (!rst_n) begin
            h_cnt      <= '0;
            v_cnt      <= '0;
            rd_addr    <= '0;
            frame_tick <= 1'b0;
            vld_pipe   <= '0;
            hs_pipe    <= '1;
            vs_pipe    <= '1;
        end else begin
            h_cnt      <= h_nxt;
            v_cnt      <= v_nxt;
            rd_addr    <= addr_nxt;
            frame_tick <= tick_c;
            vld_pipe   <= {vld_pipe[VLD_D-2:0], act_c};
            hs_pipe    <= {hs_pipe[SYN_D-2:0], hs_raw_c};
            vs_pipe    <= {vs_pipe[SYN_D-2:0], vs_raw_c};
        end
    end

    assign valid = vld_pipe[VLD_D-1];
    assign hsync = hs_pipe[SYN_D-1];
    assign vsync = vs_pipe[SYN_D-1];
    assign pix_x = h_cnt;
    assign pix_y = v_cnt;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
`timescale 1ns/1ps
// Bench for vga_scan_ctrl: full-size instance plus two shrunken rasters (latency 1 and 2)
// so whole frames fit in a short run; expectations come from an arithmetic raster model.
module tb_vga_scan_ctrl;

    typedef struct {
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
        int sh; int lat;
    } geom_t;

    logic        clk_25m = 1'b0;
    logic        rst_n   = 1'b0;
    logic [14:0] rd_addr [3];
    logic        valid [3];
    logic        hsync [3];
    logic        vsync [3];
    logic        frame_tick [3];
    logic [9:0]  pix_x [3];
    logic [9:0]  pix_y [3];

    int     checks = 0;
    int     errors = 0;
    longint n = 0;
    geom_t  g [3];

    always #20 clk_25m = ~clk_25m;

    // Cycles since the last clock edge that sampled reset.
    always @(posedge clk_25m) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    vga_scan_ctrl #(.RAM_LATENCY(1)) dut_a (
        .clk_25m(clk_25m), .rst_n(rst_n), .rd_addr(rd_addr[0]), .valid(valid[0]),
        .hsync(hsync[0]), .vsync(vsync[0]), .frame_tick(frame_tick[0]),
        .pix_x(pix_x[0]), .pix_y(pix_y[0]));

    vga_scan_ctrl #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
                    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
                    .SCALE_SHIFT(2), .RAM_LATENCY(1), .ADDR_W(15)) dut_b (
        .clk_25m(clk_25m), .rst_n(rst_n), .rd_addr(rd_addr[1]), .valid(valid[1]),
        .hsync(hsync[1]), .vsync(vsync[1]), .frame_tick(frame_tick[1]),
        .pix_x(pix_x[1]), .pix_y(pix_y[1]));

    vga_scan_ctrl #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
                    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
                    .SCALE_SHIFT(2), .RAM_LATENCY(2), .ADDR_W(15)) dut_c (
        .clk_25m(clk_25m), .rst_n(rst_n), .rd_addr(rd_addr[2]), .valid(valid[2]),
        .hsync(hsync[2]), .vsync(vsync[2]), .frame_tick(frame_tick[2]),
        .pix_x(pix_x[2]), .pix_y(pix_y[2]));

    // ---------------- reference model: raster position from cycle index ----------------
    function automatic int ht(input geom_t x);
        return x.ha + x.hf + x.hs + x.hb;
    endfunction
    function automatic int vt(input geom_t x);
        return x.va + x.vf + x.vs + x.vb;
    endfunction
    function automatic int mh(input geom_t x, input longint k);
        return int'(k % longint'(ht(x)));
    endfunction
    function automatic int mv(input geom_t x, input longint k);
        return int'((k / longint'(ht(x))) % longint'(vt(x)));
    endfunction
    function automatic bit mact(input geom_t x, input longint k);
        if (k < 0) return 1'b0;
        return (mh(x, k) < x.ha) && (mv(x, k) < x.va);
    endfunction
    function automatic int maddr(input geom_t x, input int h, input int v);
        return (v >> x.sh) * (x.ha >> x.sh) + (h >> x.sh);
    endfunction
    // Address of the most recent visible pixel strictly before cycle nn.
    function automatic int exp_addr(input geom_t x, input longint nn);
        int h;
        int v;
        if (nn - 1 < 0) return 0;
        h = mh(x, nn - 1);
        v = mv(x, nn - 1);
        if (v >= x.va) return maddr(x, x.ha - 1, x.va - 1);
        if (h >= x.ha) return maddr(x, x.ha - 1, v);
        return maddr(x, h, v);
    endfunction
    function automatic bit exp_valid(input geom_t x, input longint nn);
        return mact(x, nn - 1 - x.lat);
    endfunction
    function automatic bit exp_hs(input geom_t x, input longint nn);
        longint k = nn - 2 - x.lat;
        int h;
        if (k < 0) return 1'b1;
        h = mh(x, k);
        return !(h >= x.ha + x.hf && h < x.ha + x.hf + x.hs);
    endfunction
    function automatic bit exp_vs(input geom_t x, input longint nn);
        longint k = nn - 2 - x.lat;
        int v;
        if (k < 0) return 1'b1;
        v = mv(x, k);
        return !(v >= x.va + x.vf && v < x.va + x.vf + x.vs);
    endfunction
    function automatic bit exp_tick(input geom_t x, input longint nn);
        if (nn - 1 < 0) return 1'b0;
        return (mh(x, nn - 1) == 0) && (mv(x, nn - 1) == x.va);
    endfunction
    function automatic longint first_after(input longint q[$], input longint t);
        foreach (q[j]) if (q[j] > t) return q[j];
        return -1;
    endfunction

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk_25m);
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int r = int'($urandom_range(8, 3));
        rst_n = 1'b0;
        repeat (r) begin
            @(negedge clk_25m);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if ({pix_x[i], pix_y[i], rd_addr[i], valid[i], hsync[i], vsync[i], frame_tick[i]}
                    !== {10'd0, 10'd0, 15'd0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
                    errors++;
                    $display("FAIL reset_state[%0d] got x=%0d y=%0d a=%0d v=%b hs=%b vs=%b t=%b exp 0 0 0 0 1 1 0",
                             i, pix_x[i], pix_y[i], rd_addr[i], valid[i], hsync[i], vsync[i], frame_tick[i]);
                end
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_startup();
        longint vrise [3];
        longint hfall [3];
        logic   pv [3];
        logic   ph [3];
        for (int i = 0; i < 3; i++) begin
            vrise[i] = -1; hfall[i] = -1; pv[i] = valid[i]; ph[i] = hsync[i];
        end
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk_25m);
            for (int i = 0; i < 3; i++) begin
                if (!pv[i] && valid[i] && vrise[i] < 0) vrise[i] = n;
                if (ph[i] && !hsync[i] && hfall[i] < 0) hfall[i] = n;
                pv[i] = valid[i];
                ph[i] = hsync[i];
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (vrise[i] != longint'(1 + g[i].lat)) begin
                errors++;
                $display("FAIL first_valid_rise[%0d] got cycle %0d exp %0d", i, vrise[i], 1 + g[i].lat);
            end
            checks++;
            if (hfall[i] != longint'(g[i].ha + g[i].hf + 2 + g[i].lat)) begin
                errors++;
                $display("FAIL first_hsync_fall[%0d] got cycle %0d exp %0d", i, hfall[i],
                         g[i].ha + g[i].hf + 2 + g[i].lat);
            end
        end
    endtask

    task automatic test_scan(input int cycles);
        int e0 = errors;
        for (int c = 0; c < cycles && errors - e0 < 20; c++) begin
            @(negedge clk_25m);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (pix_x[i] !== 10'(mh(g[i], n)) || pix_y[i] !== 10'(mv(g[i], n))) begin
                    errors++;
                    $display("FAIL scan_pix[%0d] n=%0d got (%0d,%0d) exp (%0d,%0d)", i, n,
                             pix_x[i], pix_y[i], mh(g[i], n), mv(g[i], n));
                end
                checks++;
                if (rd_addr[i] !== 15'(exp_addr(g[i], n))) begin
                    errors++;
                    $display("FAIL scan_rd_addr[%0d] n=%0d got %0d exp %0d", i, n, rd_addr[i], exp_addr(g[i], n));
                end
                checks++;
                if ({valid[i], hsync[i], vsync[i], frame_tick[i]} !==
                    {exp_valid(g[i], n), exp_hs(g[i], n), exp_vs(g[i], n), exp_tick(g[i], n)}) begin
                    errors++;
                    $display("FAIL scan_ctrl[%0d] n=%0d got v/hs/vs/t=%b%b%b%b exp %b%b%b%b", i, n,
                             valid[i], hsync[i], vsync[i], frame_tick[i],
                             exp_valid(g[i], n), exp_hs(g[i], n), exp_vs(g[i], n), exp_tick(g[i], n));
                end
            end
        end
    endtask

    task automatic test_hsync_period();
        longint hf_q[$];
        longint hr_q[$];
        longint vr_q[$];
        longint vf_q[$];
        logic   ph = hsync[0];
        logic   pv = valid[0];
        longint t1;
        longint t2;
        for (int c = 0; c < 2600; c++) begin
            @(negedge clk_25m);
            if (ph && !hsync[0]) hf_q.push_back(n);
            if (!ph && hsync[0]) hr_q.push_back(n);
            if (!pv && valid[0]) vr_q.push_back(n);
            if (pv && !valid[0]) vf_q.push_back(n);
            ph = hsync[0];
            pv = valid[0];
        end
        checks++;
        if (hf_q.size() < 2 || hf_q[1] - hf_q[0] != 800) begin
            errors++;
            $display("FAIL hsync_period got %0d falls, first gap %0d exp 800", hf_q.size(),
                     (hf_q.size() >= 2) ? hf_q[1] - hf_q[0] : -1);
        end
        t1 = (hf_q.size() > 0) ? first_after(hr_q, hf_q[0]) : -1;
        checks++;
        if (hf_q.size() == 0 || t1 < 0 || t1 - hf_q[0] != 96) begin
            errors++;
            $display("FAIL hsync_width got %0d exp 96", (hf_q.size() > 0 && t1 >= 0) ? t1 - hf_q[0] : -1);
        end
        t1 = (vr_q.size() > 0) ? first_after(vf_q, vr_q[0]) : -1;
        t2 = (t1 >= 0) ? first_after(vr_q, t1) : -1;
        checks++;
        if (vr_q.size() == 0 || t1 < 0 || t1 - vr_q[0] != 640) begin
            errors++;
            $display("FAIL valid_high_run got %0d exp 640", (vr_q.size() > 0 && t1 >= 0) ? t1 - vr_q[0] : -1);
        end
        checks++;
        if (t1 < 0 || t2 < 0 || t2 - t1 != 160) begin
            errors++;
            $display("FAIL valid_low_run got %0d exp 160", (t1 >= 0 && t2 >= 0) ? t2 - t1 : -1);
        end
    endtask

    task automatic test_vsync_small();
        int     ft = ht(g[1]) * vt(g[1]);
        longint vf_q[$];
        longint vr_q[$];
        longint tk_q[$];
        logic   pvs = vsync[1];
        longint t1;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk_25m);
            if (pvs && !vsync[1]) vf_q.push_back(n);
            if (!pvs && vsync[1]) vr_q.push_back(n);
            pvs = vsync[1];
            if (frame_tick[1]) begin
                tk_q.push_back(n);
                checks++;
                if (pix_x[1] !== 10'd1 || pix_y[1] !== 10'(g[1].va)) begin
                    errors++;
                    $display("FAIL tick_position got (%0d,%0d) exp (1,%0d)", pix_x[1], pix_y[1], g[1].va);
                end
            end
        end
        checks++;
        if (vf_q.size() < 2 || vf_q[1] - vf_q[0] != longint'(ft)) begin
            errors++;
            $display("FAIL vsync_period got %0d exp %0d", (vf_q.size() >= 2) ? vf_q[1] - vf_q[0] : -1, ft);
        end
        t1 = (vf_q.size() > 0) ? first_after(vr_q, vf_q[0]) : -1;
        checks++;
        if (vf_q.size() == 0 || t1 < 0 || t1 - vf_q[0] != longint'(g[1].vs * ht(g[1]))) begin
            errors++;
            $display("FAIL vsync_width got %0d exp %0d", (vf_q.size() > 0 && t1 >= 0) ? t1 - vf_q[0] : -1,
                     g[1].vs * ht(g[1]));
        end
        checks++;
        if (tk_q.size() < 2) begin
            errors++;
            $display("FAIL tick_count got %0d exp >=2", tk_q.size());
        end
        for (int j = 1; j < tk_q.size(); j++) begin
            checks++;
            if (tk_q[j] - tk_q[j-1] != longint'(ft)) begin
                errors++;
                $display("FAIL tick_spacing got %0d exp %0d", tk_q[j] - tk_q[j-1], ft);
            end
        end
    endtask

    task automatic test_addresses();
        int tab [6][4] = '{'{0, 0, 0, 0}, '{0, 4, 0, 1}, '{0, 639, 3, 159}, '{0, 0, 4, 160},
                           '{1, 15, 7, 7}, '{2, 12, 5, 7}};
        pulse_reset();
        for (int e = 0; e < 6; e++) begin
            int k = tab[e][0];
            int c = 0;
            while (!(pix_x[k] == 10'(tab[e][1]) && pix_y[k] == 10'(tab[e][2])) && c < 4000) begin
                @(negedge clk_25m);
                c++;
            end
            @(negedge clk_25m);
            checks++;
            if (c >= 4000 || rd_addr[k] !== 15'(tab[e][3])) begin
                errors++;
                $display("FAIL addr_point[%0d] at (%0d,%0d) got %0d exp %0d (waited %0d)", k,
                         tab[e][1], tab[e][2], rd_addr[k], tab[e][3], c);
            end
        end
    endtask

    task automatic test_mid_frame_reset();
        int th = int'($urandom_range(740, 660));
        int tv = int'($urandom_range(3, 0));
        int c  = 0;
        pulse_reset();
        while (!(pix_x[0] == 10'(th) && pix_y[0] == 10'(tv)) && c < 4000) begin
            @(negedge clk_25m);
            c++;
        end
        checks++;
        if (c >= 4000) begin
            errors++;
            $display("FAIL midreset_reach got timeout exp (%0d,%0d)", th, tv);
        end
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({pix_x[i], pix_y[i], valid[i], hsync[i], vsync[i]} !== {10'd0, 10'd0, 1'b0, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL midreset_state[%0d] got x=%0d y=%0d v=%b hs=%b vs=%b exp 0 0 0 1 1",
                         i, pix_x[i], pix_y[i], valid[i], hsync[i], vsync[i]);
            end
        end
    endtask

    initial begin
        g[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 1};
        g[1] = '{16, 2, 3, 3, 8, 1, 2, 2, 2, 1};
        g[2] = '{16, 2, 3, 3, 8, 1, 2, 2, 2, 2};
        test_reset();
        test_startup();
        test_scan(6000);
        test_hsync_period();
        test_vsync_small();
        test_addresses();
        test_mid_frame_reset();
        test_scan(1500);
        test_mid_frame_reset();
        test_scan(1500);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
